// File: rtl/filter_mode_sequencer.sv
// filter_mode_sequencer
//   Control stage in front of the OFF/IDLE/IIR/FIR filter datapath. The three
//   raw mode switches are synchronised and debounced as one vector. A change of
//   requested mode is made without clicks: the output is faded to silence, the
//   filter is flushed while the new mode is applied, and the output is faded
//   back in. The gain ramp is applied to the sample stream that comes back
//   from the filter.
//
// Ports
//   clk_i           clock
//   rst_ni          synchronous active-low reset
//   sw_i[2:0]       raw asynchronous switches: [0]=enable [1]=filter on [2]=1 IIR / 0 FIR
//   sample_valid_i  one-cycle strobe per audio sample
//   data_i          signed sample from the filter datapath
//   data_o          signed gain-ramped sample, registered one cycle after the strobe
//   data_valid_o    strobe delayed by one cycle, marks data_o as new
//   mode_o          to filter: 0=OFF 1=IDLE 2=IIR 3=FIR
//   flush_o         high while the filter must clear its internal state
//   busy_o          high whenever the sequencer is not in RUN

module filter_mode_sequencer #(
    parameter int DATA_W        = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_CYC  = 1000,
    parameter int RAMP_LOG2     = 4,
    parameter int FLUSH_SAMPLES = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [2:0]               sw_i,
    input  logic                     sample_valid_i,
    input  logic signed [DATA_W-1:0] data_i,
    output logic signed [DATA_W-1:0] data_o,
    output logic                     data_valid_o,
    output logic [1:0]               mode_o,
    output logic                     flush_o,
    output logic                     busy_o
);

    localparam int GMAX   = 2 ** RAMP_LOG2;
    localparam int GAIN_W = RAMP_LOG2 + 1;
    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int FL_W   = $clog2(FLUSH_SAMPLES + 1);
    localparam int PROD_W = DATA_W + RAMP_LOG2 + 1;

    localparam logic [GAIN_W-1:0] GAIN_MAX = GAIN_W'(GMAX);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_IDLE = 2'd1,
        MODE_IIR  = 2'd2,
        MODE_FIR  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FADE_OUT,
        ST_FLUSH,
        ST_FADE_IN
    } state_e;

    // ------------------------------------------------------------------
    // Switch synchroniser and whole-vector debounce
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][2:0] sync;
    logic [2:0]                  synced;
    logic [2:0]                  candidate;
    logic [2:0]                  debounced;
    logic [DB_W-1:0]             db_cnt;

    assign synced = sync[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync      <= '0;
            candidate <= '0;
            debounced <= '0;
            db_cnt    <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sw_i};
            if (synced != candidate) begin
                candidate <= synced;
                db_cnt    <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                // counter parks here; further equal cycles just re-accept
                debounced <= candidate;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Requested filter mode from the debounced switches
    // ------------------------------------------------------------------
    mode_e target;

    always_comb begin
        target = MODE_OFF;
        if (!debounced[0]) begin
            target = MODE_OFF;
        end else if (!debounced[1]) begin
            target = MODE_IDLE;
        end else if (debounced[2]) begin
            target = MODE_IIR;
        end else begin
            target = MODE_FIR;
        end
    end

    // ------------------------------------------------------------------
    // Mode-change sequencer
    // ------------------------------------------------------------------
    state_e            state;
    logic [GAIN_W-1:0] gain;
    logic [FL_W-1:0]   flush_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= ST_RUN;
            gain      <= GAIN_MAX;
            flush_cnt <= '0;
            mode_o    <= MODE_OFF;
            flush_o   <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    gain <= GAIN_MAX;
                    if (target != mode_o) begin
                        state  <= ST_FADE_OUT;
                        busy_o <= 1'b1;
                    end
                end

                ST_FADE_OUT: begin
                    if (sample_valid_i && gain != '0) begin
                        gain <= gain - GAIN_W'(1);
                    end
                    // a reversal out of FADE_IN can arrive here already at
                    // zero gain, so silence is also detected without a strobe
                    if (gain == '0 || (sample_valid_i && gain == GAIN_W'(1))) begin
                        state     <= ST_FLUSH;
                        mode_o    <= target;
                        flush_cnt <= '0;
                        flush_o   <= 1'b1;
                    end
                end

                ST_FLUSH: begin
                    if (sample_valid_i) begin
                        if (flush_cnt == FL_W'(FLUSH_SAMPLES - 1)) begin
                            flush_cnt <= '0;
                            if (target == mode_o) begin
                                state   <= ST_FADE_IN;
                                flush_o <= 1'b0;
                            end else begin
                                // request moved on while flushing: apply it and
                                // flush for another full period
                                mode_o <= target;
                            end
                        end else begin
                            flush_cnt <= flush_cnt + FL_W'(1);
                        end
                    end
                end

                ST_FADE_IN: begin
                    if (sample_valid_i) begin
                        gain <= gain + GAIN_W'(1);
                    end
                    if (target != mode_o) begin
                        state <= ST_FADE_OUT;
                    end else if (sample_valid_i && gain == GAIN_MAX - GAIN_W'(1)) begin
                        state  <= ST_RUN;
                        busy_o <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Gain ramp on the sample stream (pre-update gain, floor shift)
    // ------------------------------------------------------------------
    logic signed [PROD_W-1:0] prod;

    always_comb begin
        prod = PROD_W'(data_i) * $signed({{(PROD_W - GAIN_W){1'b0}}, gain});
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
        end else begin
            data_valid_o <= sample_valid_i;
            if (sample_valid_i) begin
                data_o <= DATA_W'(prod >>> RAMP_LOG2);
            end
        end
    end

endmodule

// File: tb/tb_filter_mode_sequencer.sv
// tb_filter_mode_sequencer
//   Self-checking bench for filter_mode_sequencer. A behavioural reference
//   model tracks switch history, requested mode, gain and flush progress and
//   every cycle its outputs are compared with the design.

module tb_filter_mode_sequencer;

    localparam int DW   = 16;
    localparam int SS   = 2;
    localparam int DB   = 4;
    localparam int RL   = 2;
    localparam int GMAX = 4;
    localparam int FS   = 3;
    localparam int HIST = SS + DB + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [2:0]           sw = 3'b000;
    logic                 sv = 1'b0;
    logic signed [DW-1:0] din = '0;
    logic signed [DW-1:0] dout;
    logic                 dv;
    logic [1:0]           mode;
    logic                 flush;
    logic                 busy;

    always #5 clk = ~clk;

    filter_mode_sequencer #(
        .DATA_W        (DW),
        .SYNC_STAGES   (SS),
        .DEBOUNCE_CYC  (DB),
        .RAMP_LOG2     (RL),
        .FLUSH_SAMPLES (FS)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .sw_i           (sw),
        .sample_valid_i (sv),
        .data_i         (din),
        .data_o         (dout),
        .data_valid_o   (dv),
        .mode_o         (mode),
        .flush_o        (flush),
        .busy_o         (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, $signed(got), $signed(exp), $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef enum {PH_STEADY, PH_DOWN, PH_CLEAR, PH_UP} phase_e;

    phase_e m_phase = PH_STEADY;
    int     m_gain  = GMAX;
    int     m_cnt   = 0;
    int     m_mode  = 0;
    int     m_data  = 0;
    int     m_deb   = 0;
    bit     m_flush = 0;
    bit     m_busy  = 0;
    bit     m_dv    = 0;
    bit     live    = 0;
    int     hist [HIST];

    function automatic int target_of(input int s);
        if ((s & 1) == 0) return 0;
        if ((s & 2) == 0) return 1;
        if ((s & 4) != 0) return 2;
        return 3;
    endfunction

    function automatic int floor_div(input int n, input int d);
        int q;
        q = n / d;
        if (n < 0 && (n % d) != 0) q = q - 1;
        return q;
    endfunction

    always @(posedge clk) begin : model
        int  tgt;
        bit  stb;
        bit  stable;
        if (!rst_n) begin
            m_phase = PH_STEADY;
            m_gain  = GMAX;
            m_cnt   = 0;
            m_mode  = 0;
            m_data  = 0;
            m_deb   = 0;
            m_flush = 0;
            m_busy  = 0;
            m_dv    = 0;
            foreach (hist[i]) hist[i] = 0;
            live = 1;
        end else begin
            tgt = target_of(m_deb);
            stb = sv;
            m_dv = stb;
            if (stb) m_data = floor_div(int'(din) * m_gain, GMAX);
            case (m_phase)
                PH_STEADY: begin
                    if (tgt != m_mode) begin
                        m_phase = PH_DOWN;
                        m_busy  = 1;
                    end
                end
                PH_DOWN: begin
                    if (stb && m_gain > 0) m_gain--;
                    if (m_gain == 0) begin
                        m_phase = PH_CLEAR;
                        m_mode  = tgt;
                        m_cnt   = 0;
                        m_flush = 1;
                    end
                end
                PH_CLEAR: begin
                    if (stb) begin
                        m_cnt++;
                        if (m_cnt == FS) begin
                            m_cnt = 0;
                            if (tgt == m_mode) begin
                                m_phase = PH_UP;
                                m_flush = 0;
                            end else begin
                                m_mode = tgt;
                            end
                        end
                    end
                end
                PH_UP: begin
                    if (stb) m_gain++;
                    if (tgt != m_mode) begin
                        m_phase = PH_DOWN;
                    end else if (m_gain == GMAX) begin
                        m_phase = PH_STEADY;
                        m_busy  = 0;
                    end
                end
            endcase
            // raw switch value seen at each edge; a value is accepted once
            // it reaches the end of the synchroniser and then stays put
            // for DB further edges
            for (int i = HIST - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = int'(sw);
            stable = 1;
            for (int i = SS + 1; i < HIST; i++) if (hist[i] != hist[SS]) stable = 0;
            if (stable) m_deb = hist[SS];
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("mode",  32'(mode),  32'(m_mode));
            check("flush", 32'(flush), 32'(m_flush));
            check("busy",  32'(busy),  32'(m_busy));
            check("dv",    32'(dv),    32'(m_dv));
            check("data",  32'(dout),  32'(m_data));
        end
    end

    // ------------------------------------------------------------------
    // Sample strobe every 4 clocks; optional random sample data
    // ------------------------------------------------------------------
    bit rand_data = 0;

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 4;
            sv = (ph == 0);
            if (sv && rand_data) begin
                if ($urandom_range(0, 5) == 0) din = -16'sd1001;
                else din = DW'($urandom);
            end
        end
    end

    function automatic logic pick(input int sel);
        case (sel)
            0:       return busy;
            1:       return flush;
            default: return dv;
        endcase
    endfunction

    task automatic wait_until(input string tag, input int sel, input logic val, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (pick(sel) === val) break;
        end
        check(tag, 32'(pick(sel)), 32'(val));
    endtask

    task automatic wait_strobes(input int n);
        int seen;
        seen = 0;
        while (seen < n) begin
            @(posedge clk);
            if (sv) seen++;
        end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mode",  32'(mode),  32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_data",  32'(dout),  32'd0);
        check("rst_dv",    32'(dv),    32'd0);
        rst_n = 1'b1;

        // bouncing enable never gets accepted
        din = 16'sd1000;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i % 3 == 0) sw = sw ^ 3'b001;
            check("bounce_busy", 32'(busy), 32'd0);
        end
        sw = 3'b001;
        wait_until("idle_busy_rise", 0, 1'b1, 20);
        wait_until("idle_busy_fall", 0, 1'b0, 300);
        check("idle_mode", 32'(mode), 32'd1);

        // switch to IIR with a constant sample
        sw = 3'b111;
        wait_until("iir_busy_rise", 0, 1'b1, 20);
        wait_until("iir_busy_fall", 0, 1'b0, 300);
        check("iir_mode", 32'(mode), 32'd2);

        // negative sample through a full ramp (floor rounding)
        din = -16'sd1001;
        sw  = 3'b011;
        wait_until("fir_busy_rise", 0, 1'b1, 20);
        wait_until("fir_busy_fall", 0, 1'b0, 300);
        check("fir_mode", 32'(mode), 32'd3);

        // reversal during fade-in
        din = 16'sd1000;
        sw  = 3'b111;
        wait_until("rev_flush_rise", 1, 1'b1, 100);
        wait_until("rev_flush_fall", 1, 1'b0, 100);
        wait_strobes(2);
        sw = 3'b011;
        wait_until("rev_busy_fall", 0, 1'b0, 400);
        check("rev_mode", 32'(mode), 32'd3);

        // request change during flush, then reset while flushing
        sw = 3'b111;
        wait_until("chg_flush_rise", 1, 1'b1, 100);
        wait_strobes(1);
        sw = 3'b001;
        repeat (14) @(negedge clk);
        check("chg_flush_held", 32'(flush), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_mode",  32'(mode),  32'd0);
        check("midrst_flush", 32'(flush), 32'd0);
        check("midrst_busy",  32'(busy),  32'd0);
        rst_n = 1'b1;

        // randomized switch activity, data and occasional resets
        rand_data = 1;
        for (int k = 0; k < 40; k++) begin
            sw = 3'($urandom_range(0, 7));
            repeat ($urandom_range(1, 120)) @(negedge clk);
            if ($urandom_range(0, 14) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst_n = 1'b1;
            end
        end
        sw = 3'b101;
        repeat (20) @(negedge clk);
        wait_until("final_busy_fall", 0, 1'b0, 400);
        check("final_mode", 32'(mode), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
